// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer between the row and column 1-D DCT passes.
// Rows are written whole and columns are read back through a per-row lane array.

module dct_transpose_lane #(
  parameter int DW = 12
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 we_i,
  input  logic                 wbank_i,
  input  logic [7:0][DW-1:0]   wrow_i,
  input  logic                 ld_i,
  input  logic                 rbank_i,
  input  logic [2:0]           col_i,
  output logic [DW-1:0]        q_o
);
  // Row j of both banks. Storage is deliberately left unreset.
  logic [1:0][7:0][DW-1:0] mem_q;
  logic [DW-1:0]           q_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wbank_i] <= wrow_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   q_q <= '0;
    else if (ld_i) q_q <= mem_q[rbank_i][col_i];
  end

  assign q_o = q_q;
endmodule

module dct_transpose_buffer #(
  parameter int DW = 12
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0][DW-1:0] di,
  input  logic               di_valid,
  output logic               di_hold,
  input  logic [2:0]         di_cnt,
  output logic [7:0][DW-1:0] q,
  output logic               q_valid,
  input  logic               q_hold,
  output logic [2:0]         q_cnt
);
  logic [1:0] bank_full_q, bank_full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [2:0] col_q, col_d;
  logic       q_valid_q, q_valid_d;
  logic [2:0] q_cnt_q, q_cnt_d;
  logic       wr_acc, ld;

  // Hold is a function of registered state only: no path from q_hold.
  assign di_hold = di_valid & bank_full_q[wr_bank_q];
  assign wr_acc  = di_valid & ~di_hold;
  assign ld      = bank_full_q[rd_bank_q] & (~q_valid_q | ~q_hold);

  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    col_d       = col_q;
    q_valid_d   = q_valid_q;
    q_cnt_d     = q_cnt_q;
    if (wr_acc && di_cnt == 3'd7) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = ~wr_bank_q;
    end
    // Set and clear never hit the same bank: the write bank is empty, the read bank full.
    if (ld) begin
      q_valid_d = 1'b1;
      q_cnt_d   = col_q;
      col_d     = col_q + 3'd1;
      if (col_q == 3'd7) begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = ~rd_bank_q;
      end
    end else if (!q_hold) begin
      q_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      col_q       <= '0;
      q_valid_q   <= 1'b0;
      q_cnt_q     <= '0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      col_q       <= col_d;
      q_valid_q   <= q_valid_d;
      q_cnt_q     <= q_cnt_d;
    end
  end

  for (genvar j = 0; j < 8; j++) begin : g_lane
    dct_transpose_lane #(.DW(DW)) u_lane (
      .clk     (clk),
      .resetn  (resetn),
      .we_i    (wr_acc && (di_cnt == 3'(j))),
      .wbank_i (wr_bank_q),
      .wrow_i  (di),
      .ld_i    (ld),
      .rbank_i (rd_bank_q),
      .col_i   (col_q),
      .q_o     (q[j])
    );
  end

  assign q_valid = q_valid_q;
  assign q_cnt   = q_cnt_q;
endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Scoreboard bench for dct_transpose_buffer: driver pushes expected columns,
// a negedge monitor pops and compares every transferred output beat.

module tb_dct_transpose_buffer;
  localparam int DW = 12;

  typedef struct packed {
    logic [2:0]         cnt;
    logic [7:0][DW-1:0] data;
  } beat_t;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic [7:0][DW-1:0] di = '0;
  logic               di_valid = 1'b0;
  logic               di_hold;
  logic [2:0]         di_cnt = '0;
  logic [7:0][DW-1:0] q;
  logic               q_valid;
  logic               q_hold = 1'b0;
  logic [2:0]         q_cnt;

  dct_transpose_buffer #(.DW(DW)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .di       (di),
    .di_valid (di_valid),
    .di_hold  (di_hold),
    .di_cnt   (di_cnt),
    .q        (q),
    .q_valid  (q_valid),
    .q_hold   (q_hold),
    .q_cnt    (q_cnt)
  );

  always #5 clk = ~clk;

  int    n_chk = 0, n_fail = 0;
  int    cyc = 0, beats = 0, first_cyc = -1, last_cyc = -1, hold_seen = 0;
  beat_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // pat 0: 16*r+c+off; pat 1: checkerboard of extremes; pat 2: lower triangle of extremes
  function automatic logic [DW-1:0] elem(input int pat, input int off, input int r, input int c);
    int v;
    case (pat)
      0:       v = 16 * r + c + off;
      1:       v = ((r + c) % 2 == 1) ? 2047 : -2048;
      default: v = (c < r) ? 2047 : -2048;
    endcase
    return DW'(v);
  endfunction

  logic  hold_prev = 1'b0;
  beat_t held;

  always @(negedge clk) begin
    beat_t e;
    if (!resetn) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        check("hold_stable", {q_valid, q_cnt, q}, {1'b1, held.cnt, held.data});
      if (q_valid && !q_hold) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got cnt=%0d data=%0h expected no beat", q_cnt, q);
        end else begin
          e = exp_q.pop_front();
          check("beat", {q_cnt, q}, {e.cnt, e.data});
        end
        beats++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      hold_prev = q_valid && q_hold;
      held.cnt  = q_cnt;
      held.data = q;
    end
  end

  // Called #1 after a posedge; returns #1 after the edge accepting the last row.
  task automatic send_block(input int pat, input int off, input int nrows);
    beat_t e;
    for (int r = 0; r < nrows; r++) begin
      bit acc = 1'b0;
      int w = 0;
      di_valid = 1'b1;
      di_cnt   = 3'(r);
      for (int c = 0; c < 8; c++) di[c] = elem(pat, off, r, c);
      while (!acc && w < 200) begin
        @(negedge clk);
        acc = !di_hold;
        if (di_hold) hold_seen++;
        @(posedge clk);
        #1;
        w++;
      end
      if (!acc) begin
        n_chk++;
        n_fail++;
        $display("FAIL row_accept_timeout: got no accept expected row %0d accepted", r);
      end
    end
    if (nrows == 8) begin
      for (int k = 0; k < 8; k++) begin
        e.cnt = 3'(k);
        for (int j = 0; j < 8; j++) e.data[j] = elem(pat, off, j, k);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_q.size() != 0 || q_valid) && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][DW-1:0] col0;
    int b0, w;
    // Reset state, with di_valid high to exercise di_hold
    di_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q_valid", q_valid, 0);
    check("rst_q_cnt", q_cnt, 0);
    check("rst_q", q, 0);
    check("rst_di_hold", di_hold, 0);
    di_valid = 1'b0;
    resetn   = 1'b1;
    @(posedge clk);
    #1;

    // Single block, latency and no stall
    hold_seen = 0;
    send_block(0, 0, 8);
    di_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int j = 0; j < 8; j++) col0[j] = DW'(16 * j);
    check("latency_col0", {q_valid, q_cnt, q}, {1'b1, 3'd0, col0});
    wait_drain();
    check("t1_no_hold", 128'(hold_seen), 0);

    // Three back-to-back blocks, contiguous output
    hold_seen = 0;
    first_cyc = -1;
    b0        = beats;
    send_block(0, 0, 8);
    send_block(0, 1000, 8);
    send_block(0, -1000, 8);
    di_valid = 1'b0;
    wait_drain();
    check("t2_beats", 128'(beats - b0), 24);
    check("t2_contiguous", 128'(last_cyc - first_cyc), 23);
    check("t2_no_hold", 128'(hold_seen), 0);

    // Downstream stalled: two blocks fill, third row 0 is held
    q_hold = 1'b1;
    send_block(0, 0, 8);
    send_block(0, 1000, 8);
    di_valid = 1'b1;
    di_cnt   = 3'd0;
    for (int c = 0; c < 8; c++) di[c] = elem(0, -1000, 0, c);
    @(negedge clk);
    check("t3_di_hold", di_hold, 1);
    for (int j = 0; j < 8; j++) col0[j] = DW'(16 * j);
    check("t3_only_col0", {q_valid, q_cnt, q}, {1'b1, 3'd0, col0});
    repeat (3) @(posedge clk);
    #1;
    q_hold = 1'b0;
    send_block(0, -1000, 8);
    di_valid = 1'b0;
    wait_drain();

    // 5-cycle stall while column 3 is presented
    send_block(0, 500, 8);
    di_valid = 1'b0;
    w = 0;
    while (!(q_valid && q_cnt == 3'd3) && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("t4_saw_col3", {q_valid, q_cnt}, {1'b1, 3'd3});
    q_hold = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    q_hold = 1'b0;
    @(posedge clk);
    #1;
    check("t4_col4_after_release", {q_valid, q_cnt}, {1'b1, 3'd4});
    wait_drain();

    // Reset mid-block while a previous block is still draining
    send_block(0, 200, 8);
    send_block(0, -500, 5);
    di_valid = 1'b0;
    check("t5_valid_before_reset", q_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("t5_async_q_valid", q_valid, 0);
    check("t5_async_q_cnt", q_cnt, 0);
    check("t5_async_q", q, 0);
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    send_block(0, -300, 8);
    di_valid = 1'b0;
    wait_drain();

    // Extreme values, sign preserved
    send_block(1, 0, 8);
    send_block(2, 0, 8);
    di_valid = 1'b0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
